// File: rtl/shift_deserializer.sv
// shift_deserializer: LSB-first deserializer of a shift register's serial output
//   clk        rising-edge clock
//   areset_n   asynchronous active-low reset, clears all state
//   load       frame boundary; restarts word assembly (priority over ena)
//   ena        shift enable; sdata is sampled on each enabled edge
//   sdata      serial bit being shifted out this cycle
//   out_ready  consumer accepts out_data while out_valid=1
//   clr_ovf    synchronous clear of the sticky overflow flag
//   out_data   completed word, bit 0 = first bit received
//   out_valid  out_data holds an unconsumed word
//   overflow   sticky: a completed word was dropped
//   frag       one-cycle pulse: partial word discarded by load
//   bit_cnt    bits collected in the current partial word
module shift_deserializer #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             areset_n,
    input  logic             load,
    input  logic             ena,
    input  logic             sdata,
    input  logic             out_ready,
    input  logic             clr_ovf,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    output logic             overflow,
    output logic             frag,
    output logic [CNT_W-1:0] bit_cnt
);
    logic [WIDTH-1:0] asm_q, asm_d, data_q, data_d, shifted;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             valid_q, valid_d, ovf_q, ovf_d, frag_q, frag_d;
    logic             done, drain, accept, drop;

    always_comb begin
        shifted = {sdata, asm_q[WIDTH-1:1]};
        done    = !load && ena && cnt_q == CNT_W'(WIDTH - 1);
        drain   = valid_q && out_ready;
        // a completing word is taken if the slot is empty or frees on this edge
        accept  = done && (!valid_q || drain);
        drop    = done && valid_q && !out_ready;
        asm_d   = load ? '0 : ena ? (done ? '0 : shifted) : asm_q;
        cnt_d   = load ? '0 : ena ? (done ? '0 : cnt_q + 1'b1) : cnt_q;
        frag_d  = load && cnt_q != '0;
        data_d  = accept ? shifted : data_q;
        valid_d = accept ? 1'b1 : drain ? 1'b0 : valid_q;
        // a new drop wins over a simultaneous clear
        ovf_d   = drop ? 1'b1 : clr_ovf ? 1'b0 : ovf_q;
    end

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            asm_q   <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            frag_q  <= 1'b0;
        end else begin
            asm_q   <= asm_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
            frag_q  <= frag_d;
        end
    end

    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign overflow  = ovf_q;
    assign frag      = frag_q;
    assign bit_cnt   = cnt_q;
endmodule

// File: doc/shift_deserializer.md
Name: shift_deserializer

Overview:
- Downstream consumer of the 4-bit right-shift register's serial output (q[0]).
- Observes the same load/ena controls that drive the shift register and samples its q[0] on every enabled shift.
- Assembles bits LSB-first into WIDTH-bit words and presents each completed word through a one-entry valid/ready output register.
- Reports lost words (overflow) and abandoned partial words (fragment).

Parameters:
WIDTH, 8, bits per assembled output word (range 2..32)
CNT_W, $clog2(WIDTH), width of bit counter

Ports:
clk  input  1  rising-edge clock
areset_n  input  1  asynchronous active-low reset; clears all state
load  input  1  same signal that parallel-loads the shift register; marks frame boundary
ena  input  1  same shift-enable that drives the shift register
sdata  input  1  shift register q[0] (bit being shifted out this cycle)
out_ready  input  1  consumer accepts out_data when out_valid=1
clr_ovf  input  1  synchronous clear of sticky overflow
out_data  output  WIDTH  completed word, bit 0 = first bit received
out_valid  output  1  out_data holds an unconsumed word
overflow  output  1  sticky: a completed word was dropped
frag  output  1  one-cycle pulse: partial word discarded by load
bit_cnt  output  CNT_W  bits collected in the current partial word

Behaviour:
- Reset (areset_n=0, async):
  - out_data=0, out_valid=0, overflow=0, frag=0, bit_cnt=0.
  - Internal assembly register = 0.
  - Takes effect immediately, mid-word included; first edge after release behaves as idle.
- Priority each clock edge: load > ena, mirroring the shift register.
- load=1:
  - bit_cnt <= 0 and assembly register <= 0; sdata is not sampled.
  - frag <= 1 if bit_cnt != 0, else 0.
  - out_valid/out_data are unaffected.
- load=0, ena=1 (shift):
  - assembly <= {sdata, assembly[WIDTH-1:1]}.
  - If bit_cnt < WIDTH-1: bit_cnt <= bit_cnt+1.
  - If bit_cnt == WIDTH-1, the word completes: candidate word = {sdata, assembly[WIDTH-1:1]}, bit_cnt <= 0 (wrap), assembly <= 0.
- load=0, ena=0: hold all state; frag <= 0.
- frag is 0 in every cycle without a qualifying load.
- Output register (single entry):
  - Drains when out_valid & out_ready at the edge.
  - Completion with register empty, or draining the same edge: out_data <= candidate, out_valid <= 1. A simultaneous accept plus completion keeps out_valid high with the new word.
  - Completion while out_valid=1 and out_ready=0: candidate dropped, out_data held, overflow <= 1.
  - Drain without completion: out_valid <= 0; out_data holds its last value.
- Stability: out_data must not change while out_valid=1 and out_ready=0.
- overflow:
  - Sticky; cleared only by reset or clr_ovf=1.
  - If clr_ovf coincides with a new drop, set wins (overflow stays 1).
- Latency: word visible (out_valid=1) the cycle after the edge sampling its WIDTH-th bit.
- Throughput: one word per WIDTH enabled cycles; ena may be gapped arbitrarily.
- bit_cnt wraps WIDTH-1 -> 0 only on completion; it never reaches WIDTH.

Test Plan:
1. Reset, then load (sdata ignored) followed by 8 ena cycles with sdata=1,0,1,1,0,0,1,0 and out_ready=1 -> out_valid=1 one cycle after 8th shift, out_data=8'h4D, bit_cnt=0, frag=0.
2. Two back-to-back words 8'hA5 then 8'h3C with out_ready=0 throughout -> first word held as 8'hA5 with out_valid=1; overflow=1 after 16th shift; clr_ovf pulse -> overflow=0.
3. Completion on the same edge as acceptance (out_ready=1 while out_valid=1 holding 8'hFF; next word 8'h01) -> out_valid stays 1, out_data=8'h01, overflow=0.
4. 3 ena shifts then load -> frag=1 for exactly one cycle, bit_cnt=0; a following 8-bit word assembles correctly (8'h96) with no stale bits.
5. Gapped ena (ena=1 every 3rd cycle) for word 8'hC3 -> identical result to contiguous case; state held on ena=0 cycles.
6. areset_n asserted asynchronously between edges after 5 bits with out_valid=1 -> all outputs 0 immediately; after release an 8-bit word 8'h7E completes normally.
